// File: rtl/stream_demux_pkg.sv
// stream_demux shared helpers
// select range check and counter limits
package stream_demux_pkg;

  localparam int ERR_W_DEF = 8;
  localparam logic [ERR_W_DEF-1:0] ERR_MAX = '1;

  function automatic logic slot_index(
    input int unsigned sel,
    input int unsigned n
  );
    return sel < n;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// stream_demux one-entry channel register
// load wins over drain; data held on drain
module stream_demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  logic drain;

  assign drain = valid && ready && !load;

  // hold one word until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1-to-N registered demux
// per-channel slots, bad-select drop counter
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT),
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [ERR_W-1:0]       err_cnt
);

  logic             sel_ok;
  logic             busy;
  logic             accept;
  logic [N_OUT-1:0] load;

  assign sel_ok = slot_index(32'(in_sel), N_OUT);

  // target slot full and not draining blocks input
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (in_sel == SEL_W'(k)) begin
        busy = out_valid[k] && !out_ready[k];
      end
    end
  end

  assign in_ready = !busy;
  assign accept   = in_valid && in_ready;

  // one-hot load decode of the accepted word
  always_comb begin
    load = '0;
    for (int k = 0; k < N_OUT; k++) begin
      load[k] = accept && (in_sel == SEL_W'(k));
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    stream_demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[g]),
      .data  (in_data),
      .ready (out_ready[g]),
      .valid (out_valid[g]),
      .q     (out_data[g*WIDTH +: WIDTH])
    );
  end

  // count dropped words, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && !sel_ok && err_cnt != '1) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule
